pipe_stage_buffer: RTL and testbench
====================================

Name: pipe_stage_buffer

Overview:
Parametrised elastic pipeline-stage buffer that replaces fixed single-entry stage registers between pipeline stages (IF/ID, ID/EX, ...). It holds up to DEPTH entries of WIDTH-bit stage payload, such as PC and instruction concatenated. Upstream and downstream use valid/ready handshakes. It adds freeze (stall), flush (squash) with selectable priority, and a bubble value presented when empty.

Parameters:
WIDTH, 64, payload width in bits (≥1)
DEPTH, 2, number of storage entries (≥1; non-power-of-2 allowed)
BUBBLE, {WIDTH{1'b0}}, value driven on out_data when the buffer is empty (all-zero = NOP)
FREEZE_OVER_FLUSH, 1, 1: freeze masks flush; 0: flush acts even while frozen

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
freeze  in  1  stall: no push, no pop, contents held
flush  in  1  squash all stored entries
in_valid  in  1  upstream payload valid
in_ready  out  1  buffer accepts payload this cycle
in_data  in  WIDTH  upstream payload
out_valid  out  1  head entry available to downstream
out_ready  in  1  downstream accepts head this cycle
out_data  out  WIDTH  head entry, or BUBBLE when empty
count  out  $clog2(DEPTH+1)  current occupancy
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset (rst=1 at rising edge): count=0, read/write pointers=0, storage contents don't-care.
  - Post-reset outputs: out_valid=0, in_ready=1 (when freeze=0), out_data=BUBBLE, full=0, empty=1.
  - rst overrides freeze, flush and any handshake, including mid-burst.
- flush_eff = flush & ~(freeze & FREEZE_OVER_FLUSH).
- freeze_eff = freeze & ~flush_eff.
- in_ready = ~freeze_eff & ~flush_eff & ~full. This is combinational from state and inputs only, with no dependence on out_ready.
- out_valid = ~empty & ~freeze_eff & ~flush_eff.
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- Storage is circular: write at wr_ptr, read at rd_ptr. Each pointer wraps from DEPTH-1 to 0, explicitly, not by modulo 2^n.
- push only: store in_data at wr_ptr, wr_ptr++, count++.
- pop only: rd_ptr++, count--.
- push and pop in the same cycle (possible only when 0<count<DEPTH): both pointers advance, count unchanged.
- flush_eff: at the edge, count=0 and rd_ptr=wr_ptr=0. No push or pop occurs that cycle, because both handshakes are forced low.
- freeze_eff: no state change of any kind. out_data continues to show the held head; out_valid is 0.
- out_data = empty ? BUBBLE : storage[rd_ptr]. Read is combinational from registered storage.
- Latency: a payload pushed at edge N is visible on out_data/out_valid after edge N (one cycle, no fall-through when empty).
- Throughput:
  - DEPTH≥2 sustains one transfer per cycle.
  - DEPTH=1 alternates push/pop at 50% throughput. This is accepted; the block never presents a ready→ready combinational path.
- Boundaries:
  - Full with in_valid=1 and out_ready=1: pop occurs, push refused (in_ready=0). Push is accepted the next cycle.
  - Empty with out_ready=1: no pop, count stays 0.
  - Simultaneous flush and push: push discarded (in_ready=0), upstream must retry.
  - freeze=1 and flush=1 with FREEZE_OVER_FLUSH=1: contents held, flush ignored.
  - freeze=1 and flush=1 with FREEZE_OVER_FLUSH=0: buffer emptied.
- count never exceeds DEPTH and never underflows. The verification engineer asserts 0≤count≤DEPTH, full==(count==DEPTH) and empty==(count==0) every cycle.

Test Plan:
- Reset/idle (WIDTH=64, DEPTH=2): rst=1 for 2 cycles, then release → out_valid=0, out_data=0, in_ready=1, count=0, empty=1.
- Streaming: push 0xA,0xB,0xC on consecutive cycles with out_ready=1 → out_data 0xA,0xB,0xC appear one cycle after each push; count stays at 1; no cycle with in_ready=0.
- Fill/backpressure (out_ready=0): push 0x11,0x22 → count=2, full=1, in_ready=0. Third payload 0x33 is held upstream. Then assert out_ready=1 → 0x11 pops, 0x33 is accepted the following cycle, and order 0x11,0x22,0x33 is preserved.
- Flush: with 0x11,0x22 stored, pulse flush while in_valid=1 with 0x44 → next cycle count=0, out_data=BUBBLE, 0x44 not stored. Push 0x55 → wraps correctly from pointer 0.
- Freeze priority: store 0x77, then freeze=1 and flush=1 for 3 cycles.
  - FREEZE_OVER_FLUSH=1: count=1, out_data=0x77 held, out_valid=0 throughout.
  - FREEZE_OVER_FLUSH=0: count=0 after the first edge.
- Wrap/DEPTH=3 and DEPTH=1: random valid/ready traffic of 1000 payloads against a scoreboard. Requirements:
  - No loss, duplication or reordering.
  - Pointers wrap 2→0.
  - With DEPTH=1, in_ready and out_valid are never high in the same cycle.

Source files
------------

// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline-stage buffer: DEPTH-entry circular store with freeze/flush; one-cycle latency, no fall-through.
// Backpressure: in_ready depends only on state, freeze and flush (never on out_ready); a full buffer refuses pushes.
module pipe_stage_buffer #(
  parameter int               WIDTH             = 64,
  parameter int               DEPTH             = 2,
  parameter logic [WIDTH-1:0] BUBBLE            = '0,
  parameter bit               FREEZE_OVER_FLUSH = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         freeze,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int             CW       = $clog2(DEPTH+1);
  localparam int             PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]  LAST     = PW'(DEPTH-1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [2**PW];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             flush_eff;
  logic             freeze_eff;
  logic             push;
  logic             pop;

  // Pointers wrap at DEPTH-1 explicitly so non-power-of-2 depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign flush_eff  = flush & ~(freeze & FREEZE_OVER_FLUSH);
  assign freeze_eff = freeze & ~flush_eff;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign in_ready  = ~freeze_eff & ~flush_eff & ~full;
  assign out_valid = ~empty & ~freeze_eff & ~flush_eff;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = empty ? BUBBLE : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_eff) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; only occupancy decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: four instances (D2/freeze-wins, D2/flush-wins, D3, D1) checked every cycle
// against a shift-queue model, plus literal expectations and an in-order scoreboard for random traffic.
module tb_pipe_stage_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        freeze    [4];
  logic        flush     [4];
  logic        in_valid  [4];
  logic        out_ready [4];
  logic        in_ready  [4];
  logic        out_valid [4];
  logic        full      [4];
  logic        empty     [4];
  logic [63:0] in_data   [4];
  logic [63:0] out_data  [4];
  logic [1:0]  c0, c1, c2;
  logic [0:0]  c3;

  int checks = 0;
  int errors = 0;

  int          dep [4] = '{2, 2, 3, 1};
  bit          fof [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [63:0] mq  [4][4];
  int          mn  [4];
  bit          m_init = 1'b0;
  logic [63:0] rx_exp [4];

  pipe_stage_buffer #(.WIDTH(64), .DEPTH(2), .FREEZE_OVER_FLUSH(1'b1)) u0 (
    .clk(clk), .rst(rst), .freeze(freeze[0]), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .count(c0), .full(full[0]), .empty(empty[0]));

  pipe_stage_buffer #(.WIDTH(64), .DEPTH(2), .FREEZE_OVER_FLUSH(1'b0)) u1 (
    .clk(clk), .rst(rst), .freeze(freeze[1]), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .count(c1), .full(full[1]), .empty(empty[1]));

  pipe_stage_buffer #(.WIDTH(64), .DEPTH(3), .FREEZE_OVER_FLUSH(1'b1)) u2 (
    .clk(clk), .rst(rst), .freeze(freeze[2]), .flush(flush[2]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .count(c2), .full(full[2]), .empty(empty[2]));

  pipe_stage_buffer #(.WIDTH(64), .DEPTH(1), .FREEZE_OVER_FLUSH(1'b1)) u3 (
    .clk(clk), .rst(rst), .freeze(freeze[3]), .flush(flush[3]),
    .in_valid(in_valid[3]), .in_ready(in_ready[3]), .in_data(in_data[3]),
    .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_data(out_data[3]),
    .count(c3), .full(full[3]), .empty(empty[3]));

  task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %h expected %h", nm, inst, act, exp);
    end
  endtask

  function automatic logic [63:0] dcnt(input int i);
    case (i)
      0:       return 64'(c0);
      1:       return 64'(c1);
      2:       return 64'(c2);
      default: return 64'(c3);
    endcase
  endfunction

  // Model: queue head at index 0; compare, then advance to the state after the coming edge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      bit fe, fz, ir, ov, pu, po;
      logic [63:0] od;
      fe = flush[i] && !(freeze[i] && fof[i]);
      fz = freeze[i] && !fe;
      ir = !fz && !fe && (mn[i] < dep[i]);
      ov = !fz && !fe && (mn[i] > 0);
      od = (mn[i] > 0) ? mq[i][0] : 64'd0;
      if (m_init) begin
        chk("in_ready",  i, 64'(in_ready[i]),  64'(ir));
        chk("out_valid", i, 64'(out_valid[i]), 64'(ov));
        chk("out_data",  i, out_data[i],       od);
        chk("count",     i, dcnt(i),           64'(mn[i]));
        chk("full",      i, 64'(full[i]),      64'(mn[i] == dep[i]));
        chk("empty",     i, 64'(empty[i]),     64'(mn[i] == 0));
        if (i == 3) chk("d1_ready_valid_excl", i, 64'(in_ready[3] & out_valid[3]), 64'd0);
        if (i >= 2 && ov && out_ready[i] && !rst) begin
          chk("sb_order", i, out_data[i], rx_exp[i]);
          rx_exp[i]++;
        end
      end
      pu = in_valid[i] && ir;
      po = ov && out_ready[i];
      if (rst || fe) begin
        mn[i] = 0;
      end else if (!fz) begin
        if (po) begin
          for (int k = 0; k < 3; k++) mq[i][k] = mq[i][k+1];
          mn[i]--;
        end
        if (pu) begin
          mq[i][mn[i]] = in_data[i];
          mn[i]++;
        end
      end
    end
    if (rst) m_init = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [63:0] d, input logic orr, input logic fr, input logic fl);
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = v;
      in_data[i]   = d;
      out_ready[i] = orr;
      freeze[i]    = fr;
      flush[i]     = fl;
    end
  endtask

  task automatic rand_drive(input int i);
    logic [63:0] pl;
    logic        acc;
    pl = 64'd1;
    in_data[i] = pl;
    for (int c = 0; c < 20000 && rx_exp[i] <= 64'd1000; c++) begin
      @(negedge clk);
      acc = in_valid[i] & in_ready[i];
      @(posedge clk);
      #1;
      if (acc) pl++;
      if (pl > 64'd1000) in_valid[i] = 1'b0;
      else if (!in_valid[i] || acc) in_valid[i] = ($urandom_range(0, 3) != 0);
      in_data[i]   = pl;
      out_ready[i] = ($urandom_range(0, 3) != 0);
    end
    chk("rx_complete", i, rx_exp[i], 64'd1001);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      freeze[i] = 1'b0; flush[i] = 1'b0; in_valid[i] = 1'b0; out_ready[i] = 1'b0;
      in_data[i] = 64'd0; rx_exp[i] = 64'd1; mn[i] = 0;
    end
    repeat (2) step();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 0, 64'(out_valid[0]), 64'd0);
    chk("rst_out_data",  0, out_data[0],       64'd0);
    chk("rst_in_ready",  0, 64'(in_ready[0]),  64'd1);
    chk("rst_count",     0, 64'(c0),           64'd0);
    chk("rst_empty",     0, 64'(empty[0]),     64'd1);

    // Streaming A, B, C with the sink always ready.
    drv(1, 64'hA, 1, 0, 0); #1 chk("stream_ready_a", 0, 64'(in_ready[0]), 64'd1);
    step(); chk("stream_a", 0, out_data[0], 64'hA); chk("stream_cnt_a", 0, 64'(c0), 64'd1);
    drv(1, 64'hB, 1, 0, 0); #1 chk("stream_ready_b", 0, 64'(in_ready[0]), 64'd1);
    step(); chk("stream_b", 0, out_data[0], 64'hB); chk("stream_cnt_b", 0, 64'(c0), 64'd1);
    drv(1, 64'hC, 1, 0, 0); #1 chk("stream_ready_c", 0, 64'(in_ready[0]), 64'd1);
    step(); chk("stream_c", 0, out_data[0], 64'hC); chk("stream_cnt_c", 0, 64'(c0), 64'd1);
    drv(0, 64'h0, 1, 0, 0);
    step(); chk("drain_empty", 0, 64'(empty[0]), 64'd1); chk("drain_bubble", 0, out_data[0], 64'd0);
    step(); chk("empty_pop_cnt", 0, 64'(c0), 64'd0);

    // Fill and backpressure.
    drv(1, 64'h11, 0, 0, 0); step();
    drv(1, 64'h22, 0, 0, 0); step();
    drv(1, 64'h33, 0, 0, 0); #1;
    chk("fill_cnt", 0, 64'(c0), 64'd2); chk("fill_full", 0, 64'(full[0]), 64'd1);
    chk("fill_ready", 0, 64'(in_ready[0]), 64'd0); chk("fill_head", 0, out_data[0], 64'h11);
    step(); chk("hold_cnt", 0, 64'(c0), 64'd2);
    drv(1, 64'h33, 1, 0, 0); #1 chk("full_pop_ready", 0, 64'(in_ready[0]), 64'd0);
    step(); chk("bp_head_22", 0, out_data[0], 64'h22); chk("bp_ready_back", 0, 64'(in_ready[0]), 64'd1);
    step(); chk("bp_head_33", 0, out_data[0], 64'h33); chk("bp_cnt", 0, 64'(c0), 64'd1);
    drv(0, 64'h0, 1, 0, 0); step(); chk("bp_drained", 0, 64'(c0), 64'd0);

    // Flush with a simultaneous push attempt, then restart from pointer 0.
    drv(1, 64'h11, 0, 0, 0); step();
    drv(1, 64'h22, 0, 0, 0); step();
    drv(1, 64'h44, 0, 0, 1); #1 chk("flush_ready", 0, 64'(in_ready[0]), 64'd0);
    step(); drv(0, 64'h0, 0, 0, 0); #1;
    chk("flush_cnt", 0, 64'(c0), 64'd0); chk("flush_bubble", 0, out_data[0], 64'd0);
    chk("flush_cnt1", 1, 64'(c1), 64'd0);
    drv(1, 64'h55, 0, 0, 0); step(); drv(0, 64'h0, 0, 0, 0); #1;
    chk("post_flush_head", 0, out_data[0], 64'h55); chk("post_flush_cnt", 0, 64'(c0), 64'd1);
    drv(0, 64'h0, 1, 0, 0); step(); chk("post_flush_drain", 0, 64'(c0), 64'd0);

    // Freeze and flush together: u0 holds, u1 empties.
    drv(1, 64'h77, 0, 0, 0); step();
    drv(0, 64'h0, 0, 1, 1); #1;
    chk("frz_valid0", 0, 64'(out_valid[0]), 64'd0); chk("frz_valid1", 1, 64'(out_valid[1]), 64'd0);
    for (int n = 0; n < 3; n++) begin
      step();
      chk("frz_cnt0", 0, 64'(c0), 64'd1); chk("frz_data0", 0, out_data[0], 64'h77);
      chk("frz_valid0", 0, 64'(out_valid[0]), 64'd0); chk("frz_cnt1", 1, 64'(c1), 64'd0);
    end
    drv(0, 64'h0, 0, 0, 0); #1;
    chk("unfrz_valid", 0, 64'(out_valid[0]), 64'd1); chk("unfrz_data", 0, out_data[0], 64'h77);
    drv(0, 64'h0, 1, 0, 0); step(); chk("unfrz_drain", 0, 64'(c0), 64'd0);

    // Reset mid-burst overrides the handshake.
    drv(1, 64'h99, 0, 0, 0); step();
    drv(1, 64'hAA, 0, 0, 0); rst = 1'b1; step(); rst = 1'b0;
    drv(0, 64'h0, 0, 0, 0); #1;
    chk("midrst_cnt0", 0, 64'(c0), 64'd0); chk("midrst_empty1", 1, 64'(empty[1]), 64'd1);

    fork
      rand_drive(2);
      rand_drive(3);
    join
    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
